// File: rtl/btb_types_pkg.sv
// Shared types for the branch target buffer.
// BTB_HYSTERESIS_EN selects 2-bit saturating counters over 1-bit last-outcome.
package btb_types_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

`ifdef BTB_HYSTERESIS_EN
  typedef logic [1:0] cnt_t;
  localparam cnt_t CNT_RST = WNT;

  function automatic cnt_t cnt_alloc(input logic tk);
    return tk ? WT : WNT;
  endfunction

  function automatic logic cnt_taken(input cnt_t c);
    return c[1];
  endfunction
`else
  typedef logic cnt_t;
  localparam cnt_t CNT_RST = 1'b0;

  function automatic cnt_t cnt_alloc(input logic tk);
    return tk;
  endfunction

  function automatic logic cnt_taken(input cnt_t c);
    return c;
  endfunction
`endif

  typedef enum logic {IDLE, SWEEP} btb_state_t;

endpackage

// File: rtl/btb_sat_counter.sv
// Next prediction state from current state and resolved outcome.
// BTB_HYSTERESIS_EN: saturating 2-bit step; otherwise last outcome.
module btb_sat_counter
  import btb_types_pkg::*;
(
  input  cnt_t cnt_i,
  input  logic taken_i,
  output cnt_t cnt_o
);

`ifdef BTB_HYSTERESIS_EN
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i && (cnt_i != ST))
      cnt_o = cnt_i + 2'd1;
    else if (!taken_i && (cnt_i != SNT))
      cnt_o = cnt_i - 2'd1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = cnt_i;
  assign cnt_o = taken_i;
`endif

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry prediction and invalidate sweep.
// Prediction depth selected by BTB_HYSTERESIS_EN (see btb_types_pkg).
module branch_target_buffer
  import btb_types_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] IFpc,
  output logic        PRhit,
  output logic        PRtaken,
  output logic [31:0] PRtarget,
  input  logic        MMupdate,
  input  logic [31:0] MMpc,
  input  logic        MMtaken,
  input  logic [31:0] MMtarget,
  input  logic        flush,
  output logic        busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    cnt_t             cnt;
  } entry_t;

  entry_t           ent_q [ENTRIES];
  entry_t           ent_d [ENTRIES];
  btb_state_t       state_q, state_d;
  logic [IDX_W-1:0] sidx_q, sidx_d;

  logic [IDX_W-1:0] if_idx, mm_idx;
  logic [TAG_W-1:0] if_tag, mm_tag;
  entry_t           if_ent, mm_ent;
  logic             mm_hit;
  cnt_t             cnt_nxt;

  logic unused_pc;
  assign unused_pc = ^{IFpc[1:0], MMpc[1:0]};

  assign if_idx = IFpc[IDX_W+1:2];
  assign if_tag = IFpc[31:IDX_W+2];
  assign mm_idx = MMpc[IDX_W+1:2];
  assign mm_tag = MMpc[31:IDX_W+2];

  assign if_ent = ent_q[if_idx];
  assign mm_ent = ent_q[mm_idx];
  assign mm_hit = mm_ent.valid && (mm_ent.tag == mm_tag);

  btb_sat_counter u_cnt (
    .cnt_i   (mm_ent.cnt),
    .taken_i (MMtaken),
    .cnt_o   (cnt_nxt)
  );

  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    ent_d   = ent_q;
    unique case (state_q)
      IDLE: begin
        // flush has priority; a coincident update is dropped
        if (flush) begin
          state_d = SWEEP;
          sidx_d  = '0;
        end else if (MMupdate) begin
          if (mm_hit) begin
            ent_d[mm_idx].cnt = cnt_nxt;
            if (MMtaken)
              ent_d[mm_idx].target = MMtarget;
          end else begin
            ent_d[mm_idx].valid  = 1'b1;
            ent_d[mm_idx].tag    = mm_tag;
            ent_d[mm_idx].target = MMtarget;
            ent_d[mm_idx].cnt    = cnt_alloc(MMtaken);
          end
        end
      end
      SWEEP: begin
        ent_d[sidx_q].valid = 1'b0;
        sidx_d = sidx_q + ONE;
        if (sidx_q == LAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i].valid  <= 1'b0;
        ent_q[i].tag    <= '0;
        ent_q[i].target <= '0;
        ent_q[i].cnt    <= CNT_RST;
      end
      state_q <= IDLE;
      sidx_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      state_q <= state_d;
      sidx_q  <= sidx_d;
    end
  end

  assign busy     = (state_q == SWEEP);
  assign PRhit    = !busy && if_ent.valid && (if_ent.tag == if_tag);
  assign PRtaken  = PRhit && cnt_taken(if_ent.cnt);
  assign PRtarget = PRhit ? if_ent.target : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer, ENTRIES = 4.
// Expected outcomes follow the BTB_HYSTERESIS_EN setting of the build.
module tb_branch_target_buffer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] IFpc;
  logic        PRhit, PRtaken, busy;
  logic [31:0] PRtarget;
  logic        MMupdate, MMtaken, flush;
  logic [31:0] MMpc, MMtarget;

  branch_target_buffer #(.ENTRIES(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .IFpc     (IFpc),
    .PRhit    (PRhit),
    .PRtaken  (PRtaken),
    .PRtarget (PRtarget),
    .MMupdate (MMupdate),
    .MMpc     (MMpc),
    .MMtaken  (MMtaken),
    .MMtarget (MMtarget),
    .flush    (flush),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

`ifdef BTB_HYSTERESIS_EN
  localparam logic TK_AFTER_NT = 1'b1;
`else
  localparam logic TK_AFTER_NT = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic        h;
    logic        t;
    logic [31:0] tg;
    logic        b;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // monitor: compares the pending expectation away from the active edge
  always @(negedge CLK) begin
    if (chk_req) begin
      exp_t e;
      chk_req = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        e = exp_q.pop_front();
        cmp({e.nm, ".hit"},    {31'd0, PRhit},   {31'd0, e.h});
        cmp({e.nm, ".taken"},  {31'd0, PRtaken}, {31'd0, e.t});
        cmp({e.nm, ".target"}, PRtarget,         e.tg);
        cmp({e.nm, ".busy"},   {31'd0, busy},    {31'd0, e.b});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] tg, input logic b,
                      input string nm);
    IFpc = pc;
    exp_q.push_back('{nm, h, t, tg, b});
    chk_req = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg);
    MMupdate = 1'b1;
    MMpc     = pc;
    MMtaken  = tk;
    MMtarget = tg;
  endtask

  task automatic noup();
    MMupdate = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    IFpc = '0;
    MMupdate = 1'b0;
    MMpc = '0;
    MMtaken = 1'b0;
    MMtarget = '0;
    flush = 1'b0;

    // reset state
    look(32'h40, 0, 0, 0, 0, "reset");
    step();
    step();
    nRST = 1'b1;

    // allocate 0x44; same-cycle lookup sees old contents
    upd(32'h44, 1, 32'h100);
    look(32'h44, 0, 0, 0, 0, "same_cycle");
    step();
    noup();
    look(32'h44, 1, 1, 32'h100, 0, "alloc_hit");
    step();
    look(32'h54, 0, 0, 0, 0, "alias_miss");
    step();

    // taken then not-taken with a different target
    upd(32'h44, 1, 32'h100);
    look(32'h44, 1, 1, 32'h100, 0, "pre_tk");
    step();
    upd(32'h44, 0, 32'h200);
    look(32'h44, 1, 1, 32'h100, 0, "pre_nt");
    step();
    noup();
    look(32'h44, 1, TK_AFTER_NT, 32'h100, 0, "after_nt");
    step();

    // five taken updates: prediction must stay taken, no wrap
    for (int i = 0; i < 5; i++) begin
      upd(32'h44, 1, 32'h100);
      look(32'h44, 1, (i == 0) ? TK_AFTER_NT : 1'b1, 32'h100, 0,
           "sat_loop");
      step();
    end
    upd(32'h44, 0, 32'h200);
    look(32'h44, 1, 1, 32'h100, 0, "sat_top");
    step();
    noup();
    look(32'h44, 1, TK_AFTER_NT, 32'h100, 0, "sat_step_down");
    step();

    // alias replaces occupant
    upd(32'h54, 1, 32'h300);
    look(32'h44, 1, TK_AFTER_NT, 32'h100, 0, "pre_replace");
    step();
    noup();
    look(32'h44, 0, 0, 0, 0, "replaced_miss");
    step();
    look(32'h54, 1, 1, 32'h300, 0, "replacer_hit");
    step();

    // fill the remaining indices
    upd(32'h50, 1, 32'h500);
    step();
    upd(32'h58, 1, 32'h580);
    step();
    upd(32'h5C, 0, 32'h5C0);
    step();
    noup();
    look(32'h5C, 1, 0, 32'h5C0, 0, "fill_nt");
    step();

    // flush with coincident update: flush wins
    flush = 1'b1;
    upd(32'h60, 1, 32'h600);
    look(32'h50, 1, 1, 32'h500, 0, "flush_cycle");
    step();
    flush = 1'b0;
    noup();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) upd(32'h64, 1, 32'h700);
      look(32'h58, 0, 0, 0, 1, "sweep_busy");
      step();
    end
    // first idle cycle accepts an update
    upd(32'h68, 1, 32'h800);
    look(32'h50, 0, 0, 0, 0, "post_50");
    step();
    noup();
    look(32'h54, 0, 0, 0, 0, "post_54");
    step();
    look(32'h5C, 0, 0, 0, 0, "post_5C");
    step();
    look(32'h60, 0, 0, 0, 0, "dropped_flush_upd");
    step();
    look(32'h64, 0, 0, 0, 0, "dropped_sweep_upd");
    step();
    look(32'h68, 1, 1, 32'h800, 0, "first_idle_upd");
    step();

    // reset during the second sweep cycle
    flush = 1'b1;
    look(32'h68, 1, 1, 32'h800, 0, "flush2");
    step();
    flush = 1'b0;
    look(32'h68, 0, 0, 0, 1, "sweep2_c1");
    step();
    nRST = 1'b0;
    look(32'h68, 0, 0, 0, 0, "reset_in_sweep");
    step();
    nRST = 1'b1;
    upd(32'h70, 1, 32'h900);
    look(32'h68, 0, 0, 0, 0, "post_reset_idle");
    step();
    noup();
    look(32'h70, 1, 1, 32'h900, 0, "post_reset_upd");
    step();

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0 || chk_req) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised successor to the four-entry branch buffer. It is a direct-mapped branch target buffer with `ENTRIES` entries, per-entry prediction state, and a sequential invalidate sweep. It sits beside the fetch stage: it is looked up combinationally with the IF PC and updated with resolved BEQ/BNE outcomes from the MEM stage. A hit with a taken prediction lets fetch redirect to the stored target.

## Interface
Parameters:
- `ENTRIES`, default 4: number of entries; power of two, minimum 2. `IDX_W = $clog2(ENTRIES)`.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `IFpc`  in  32  fetch PC to look up.
- `PRhit`  out  1  indexed entry is valid and its tag matches, and no sweep is in progress.
- `PRtaken`  out  1  `PRhit` and the entry predicts taken.
- `PRtarget`  out  32  stored target when `PRhit`, else 0.
- `MMupdate`  in  1  a resolved conditional branch (BEQ/BNE) is in MEM this cycle.
- `MMpc`  in  32  PC of the resolved branch.
- `MMtaken`  in  1  actual branch outcome.
- `MMtarget`  in  32  computed branch target.
- `flush`  in  1  request invalidation of all entries.
- `busy`  out  1  invalidate sweep in progress.

## Operation
- PC split: index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`. Bits `[1:0]` are ignored.
- Entry fields: `valid`, `tag`, `target` (32 bits), `cnt` (prediction state).
- Lookup is purely combinational from `IFpc` and current entry state. There is no write-to-read bypass.
- Update, when `MMupdate` is high and state is IDLE:
  - Hit (valid and tag match): `cnt` moves one step toward `MMtaken`, saturating. `target` is overwritten with `MMtarget` only if `MMtaken`.
  - Miss: allocate the entry. Set valid = 1, tag = MMpc tag, target = `MMtarget`, and `cnt` = WT if `MMtaken`, else WNT. This allocation overwrites any previous occupant.
- Counter encoding (2-bit): SNT = 0, WNT = 1, WT = 2, ST = 3. Predict taken when `cnt[1]` = 1.
- Sweep FSM:
  - States are IDLE and SWEEP, with a sweep pointer `sidx` of width `IDX_W`.
  - IDLE: `flush` = 1 moves to SWEEP with `sidx` = 0.
  - SWEEP: each cycle clear `valid[sidx]` and increment `sidx`. On the cycle `sidx` = ENTRIES-1, clear that entry and return to IDLE.
  - Tag, target and cnt are left unchanged by the sweep.
- `busy` = (state == SWEEP).
- While in SWEEP:
  - `PRhit` = 0, `PRtaken` = 0 and `PRtarget` = 0.
  - `MMupdate` is ignored and the update is dropped.
  - `flush` is ignored.
- Simultaneous `flush` and `MMupdate` in IDLE: the flush wins and the update is dropped.

## Timing
- Lookup has zero latency (combinational).
- An update is written at the posedge where `MMupdate` is sampled high. It is visible to lookups from the next cycle onward.
- A same-index lookup in the update cycle returns the old contents.
- Sweep:
  - `busy` rises the cycle after `flush` is sampled and stays high for exactly ENTRIES cycles.
  - The first update accepted again is on the cycle `busy` = 0.
- Reset values (asynchronous, take effect immediately):
  - All `valid` = 0, `tag` = 0, `target` = 0, `cnt` = WNT.
  - State = IDLE, `sidx` = 0.
  - Outputs: `PRhit` = 0, `PRtaken` = 0, `PRtarget` = 0, `busy` = 0.
- Reset asserted during SWEEP aborts the sweep immediately and applies full reset state.

## Configuration
- `BTB_HYSTERESIS_EN` defined: 2-bit saturating counters as described in Operation.
- `BTB_HYSTERESIS_EN` undefined:
  - `cnt` is 1 bit holding the last outcome.
  - Any update (hit or allocation) sets `cnt` = `MMtaken`; predict taken when `cnt` = 1.
  - Reset value of `cnt` is 0.
- All other behaviour is identical in both builds.

## Structure
- Package `btb_types_pkg`:
  - `cnt_t` (2-bit, or 1-bit when the macro is undefined).
  - Constants SNT, WNT, WT, ST.
  - `btb_state_t` enum {IDLE, SWEEP}.
- The entry struct is declared inside the module, because tag width depends on `ENTRIES`.
- One sub-module, `btb_sat_counter`: combinational next-`cnt` from current `cnt` and `MMtaken`, with saturation. It is `ifdef`-selected per the macro.

## Test plan
All scenarios use ENTRIES = 4, so index = `pc[3:2]` and tag = `pc[31:4]`.
1. Reset, then `IFpc` = 0x00000040 -> `PRhit` = 0, `PRtaken` = 0, `PRtarget` = 0, `busy` = 0.
2. Update with `MMpc` = 0x44, taken, target 0x100. Next cycle:
   - `IFpc` = 0x44 -> hit = 1, taken = 1, target = 0x100.
   - `IFpc` = 0x54 (same index, different tag) -> hit = 0.
   - A same-cycle lookup of 0x44 during the update -> hit = 0.
3. From scenario 2, apply taken, then not-taken -> `PRtaken` = 1 with the macro (ST -> WT), 0 without it. Apply five further taken updates -> `cnt` stays ST, no wrap.
4. Hit entry 0x44 with a not-taken update carrying `MMtarget` = 0x200 -> `PRtarget` remains 0x100. Then update 0x54 taken, target 0x300 -> 0x44 misses and 0x54 hits with target 0x300.
5. Fill indices 0-3, then pulse `flush` together with `MMupdate`:
   - The update is dropped.
   - `busy` = 1 for exactly 4 cycles.
   - An update issued mid-sweep is dropped.
   - Afterwards, all four PCs miss.
6. Assert `nRST` low during the second cycle of a sweep -> `busy` = 0 and all outputs 0 immediately. After release, the FSM is IDLE and a new update/lookup works normally.
